// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Generic pipeline stage register placed between two adjacent MIPS stages
// (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control bundle, a data bundle
// and a valid bit. The hazard unit can hold the stage (stall) or turn it into
// a bubble (flush). Two saturating debug counters track how often the stage
// was held with a real instruction and how many real instructions were
// squashed.
//
// Valid semantics: out_valid=1 means the stage holds a real instruction. There
// is no ready signal; back-pressure comes only from the hazard unit via stall.
// When out_valid=0 the control bundle is forced to zero, so a bubble can never
// raise a register-file, HI/LO or memory enable downstream.
//
// Ports:
//   Clk         in   1       clock, rising edge
//   Reset       in   1       synchronous, active-high reset
//   in_valid    in   1       upstream stage holds a real instruction
//   in_ctrl     in   CTRL_W  upstream control bundle
//   in_data     in   DATA_W  upstream data bundle
//   stall       in   1       hold the current contents
//   flush       in   1       insert a bubble (overrides stall)
//   cnt_clr     in   1       synchronous clear of both counters
//   out_valid   out  1       stage holds a real instruction
//   out_ctrl    out  CTRL_W  registered control bundle, 0 when out_valid=0
//   out_data    out  DATA_W  registered data bundle
//   stall_cnt   out  CNT_W   cycles held with a valid instruction
//   bubble_cnt  out  CNT_W   bubbles created by flush of a real instruction
//
// All outputs come straight from flops; there is no input-to-output path.
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int CTRL_W              = 16,
  parameter int DATA_W              = 96,
  parameter bit CLEAR_DATA_ON_FLUSH = 1'b0,
  parameter int CNT_W               = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              stall,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic              w_stall_inc;
  logic              w_bubble_inc;

  // A stall only counts when it actually holds a real instruction; flush wins
  // over stall, so a combined stall+flush edge counts as a bubble only.
  assign w_stall_inc  = stall & ~flush & r_valid;
  // A flush only counts when it squashes something real: either the held
  // instruction or the one that would have been loaded on this edge.
  assign w_bubble_inc = flush & (r_valid | in_valid);

  // Stage contents: Reset > flush > stall > load.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      if (CLEAR_DATA_ON_FLUSH) begin
        r_data <= '0;
      end
    end else if (!stall) begin
      r_valid <= in_valid;
      r_ctrl  <= in_valid ? in_ctrl : '0;
      r_data  <= in_data;
    end
  end

  // Debug counters: Reset > cnt_clr > saturating increment.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else if (cnt_clr) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_bubble_inc && (r_bubble_cnt != CNT_MAX)) begin
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end
    end
  end

  assign out_valid  = r_valid;
  assign out_ctrl   = r_ctrl;
  assign out_data   = r_data;
  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Directed bench for pipe_stage_reg. Two instances share one stimulus:
//   dut_a: defaults (CNT_W=16, CLEAR_DATA_ON_FLUSH=0)
//   dut_b: CNT_W=4, CLEAR_DATA_ON_FLUSH=1 (saturation and data-clear cases)
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, i.e. after the edge they were updated on.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int CTRL_W = 16;
  localparam int DATA_W = 96;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  logic              in_valid;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              stall;
  logic              flush;
  logic              cnt_clr;

  logic              a_valid;
  logic [CTRL_W-1:0] a_ctrl;
  logic [DATA_W-1:0] a_data;
  logic [15:0]       a_scnt;
  logic [15:0]       a_bcnt;

  logic              b_valid;
  logic [CTRL_W-1:0] b_ctrl;
  logic [DATA_W-1:0] b_data;
  logic [3:0]        b_scnt;
  logic [3:0]        b_bcnt;

  int n_vec  = 0;
  int n_fail = 0;

  pipe_stage_reg #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA_ON_FLUSH(1'b0), .CNT_W(16)
  ) dut_a (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ctrl(in_ctrl),
    .in_data(in_data), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .out_valid(a_valid), .out_ctrl(a_ctrl), .out_data(a_data),
    .stall_cnt(a_scnt), .bubble_cnt(a_bcnt)
  );

  pipe_stage_reg #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA_ON_FLUSH(1'b1), .CNT_W(4)
  ) dut_b (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ctrl(in_ctrl),
    .in_data(in_data), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .out_valid(b_valid), .out_ctrl(b_ctrl), .out_data(b_data),
    .stall_cnt(b_scnt), .bubble_cnt(b_bcnt)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c,
                       input logic [DATA_W-1:0] d, input logic st,
                       input logic fl, input logic clr, input logic rst);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
    stall    = st;
    flush    = fl;
    cnt_clr  = clr;
    Reset    = rst;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic v,
                         input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                         input logic [15:0] s, input logic [15:0] b);
    check({tag, ".a_valid"}, 128'(a_valid), 128'(v));
    check({tag, ".a_ctrl"},  128'(a_ctrl),  128'(c));
    check({tag, ".a_data"},  128'(a_data),  128'(d));
    check({tag, ".a_scnt"},  128'(a_scnt),  128'(s));
    check({tag, ".a_bcnt"},  128'(a_bcnt),  128'(b));
  endtask

  task automatic check_b(input string tag, input logic v,
                         input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                         input logic [3:0] s, input logic [3:0] b);
    check({tag, ".b_valid"}, 128'(b_valid), 128'(v));
    check({tag, ".b_ctrl"},  128'(b_ctrl),  128'(c));
    check({tag, ".b_data"},  128'(b_data),  128'(d));
    check({tag, ".b_scnt"},  128'(b_scnt),  128'(s));
    check({tag, ".b_bcnt"},  128'(b_bcnt),  128'(b));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    drive(1'b1, 16'h7777, 96'h7777, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    check_a("reset", 1'b0, 16'h0, 96'h0, 16'd0, 16'd0);
    check_b("reset", 1'b0, 16'h0, 96'h0, 4'd0, 4'd0);

    // Basic 1-cycle load.
    drive(1'b1, 16'hA5A5, 96'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_a("load", 1'b1, 16'hA5A5, 96'h1234, 16'd0, 16'd0);
    check_b("load", 1'b1, 16'hA5A5, 96'h1234, 4'd0, 4'd0);

    // Load 00F1 then stall 3 edges with changing inputs.
    drive(1'b1, 16'h00F1, 96'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h1111, 96'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check_a("stall1", 1'b1, 16'h00F1, 96'h55, 16'd1, 16'd0);
    drive(1'b1, 16'h2222, 96'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h3333, 96'h33, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check_a("stall3", 1'b1, 16'h00F1, 96'h55, 16'd3, 16'd0);
    check_b("stall3", 1'b1, 16'h00F1, 96'h55, 4'd3, 4'd0);
    drive(1'b1, 16'h0ABC, 96'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_a("release", 1'b1, 16'h0ABC, 96'h77, 16'd3, 16'd0);

    // stall + flush together: flush wins, one bubble, stall count unchanged.
    drive(1'b1, 16'h0BAD, 96'h99, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check_a("stall_flush", 1'b0, 16'h0, 96'h77, 16'd3, 16'd1);
    check_b("stall_flush", 1'b0, 16'h0, 96'h0, 4'd3, 4'd1);

    // Invalid input gates ctrl; data still loads.
    drive(1'b0, 16'hFFFF, 96'h42, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_a("invalid_in", 1'b0, 16'h0, 96'h42, 16'd3, 16'd1);
    check_b("invalid_in", 1'b0, 16'h0, 96'h42, 4'd3, 4'd1);

    // Flush of an empty stage with in_valid=0 does not count.
    drive(1'b0, 16'hFFFF, 96'h43, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check_a("empty_flush", 1'b0, 16'h0, 96'h42, 16'd3, 16'd1);
    check_b("empty_flush", 1'b0, 16'h0, 96'h0, 4'd3, 4'd1);

    // Stalling an empty stage does not count.
    drive(1'b1, 16'h4444, 96'h44, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check_a("empty_stall", 1'b0, 16'h0, 96'h42, 16'd3, 16'd1);

    // Load a valid instruction, then stall 20 edges: B saturates at 15.
    drive(1'b1, 16'h0C0C, 96'hC0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_a("load_c", 1'b1, 16'h0C0C, 96'hC0, 16'd3, 16'd1);
    drive(1'b1, 16'h5A5A, 96'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      in_ctrl = CTRL_W'(i);
      step();
    end
    check_a("stall20", 1'b1, 16'h0C0C, 96'hC0, 16'd23, 16'd1);
    check_b("stall20", 1'b1, 16'h0C0C, 96'hC0, 4'd15, 4'd1);

    // cnt_clr while still stalled: clear wins on that edge, then counts again.
    cnt_clr = 1'b1;
    step();
    check_a("cnt_clr", 1'b1, 16'h0C0C, 96'hC0, 16'd0, 16'd0);
    check_b("cnt_clr", 1'b1, 16'h0C0C, 96'hC0, 4'd0, 4'd0);
    cnt_clr = 1'b0;
    step();
    check_a("after_clr", 1'b1, 16'h0C0C, 96'hC0, 16'd1, 16'd0);
    check_b("after_clr", 1'b1, 16'h0C0C, 96'hC0, 4'd1, 4'd0);

    // Flush a valid instruction so both counters are nonzero.
    drive(1'b1, 16'h0D0D, 96'hD0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check_a("flush_valid", 1'b0, 16'h0, 96'hC0, 16'd1, 16'd1);
    check_b("flush_valid", 1'b0, 16'h0, 96'h0, 4'd1, 4'd1);
    drive(1'b1, 16'h0D0D, 96'hD0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_a("load_d", 1'b1, 16'h0D0D, 96'hD0, 16'd1, 16'd1);

    // Mid-operation reset discards everything on that edge.
    drive(1'b1, 16'h0F0F, 96'hF0, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    check_a("mid_reset", 1'b0, 16'h0, 96'h0, 16'd0, 16'd0);
    check_b("mid_reset", 1'b0, 16'h0, 96'h0, 4'd0, 4'd0);
    drive(1'b1, 16'h0E0E, 96'hE0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_a("post_reset", 1'b1, 16'h0E0E, 96'hE0, 16'd0, 16'd0);
    check_b("post_reset", 1'b1, 16'h0E0E, 96'hE0, 4'd0, 4'd0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic parametrised pipeline stage register that replaces the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Carries one control bundle, one data bundle and a valid bit. Adds hazard-unit hooks: stall (hold) and flush (bubble insertion).
- Keeps saturating per-stage stall and bubble counters for pipeline debug.
- One instance is placed between each pair of adjacent MIPS stages.

Parameters:
- CTRL_W, 16: width of the control-signal bundle (ALU op, RF/HI/LO enables, memory controls, ...).
- DATA_W, 96: width of the datapath bundle (PC, operands, immediate, destination register, ...).
- CLEAR_DATA_ON_FLUSH, 0: 1 = data bundle is zeroed on flush/reset; 0 = data bundle is held on flush, zeroed only on reset.
- CNT_W, 16: width of the stall and bubble counters.

Ports:
- Clk  in  1  clock; all state updates on the rising edge
- Reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream stage holds a real instruction
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  DATA_W  upstream data bundle
- stall  in  1  hold the current contents (from the hazard unit)
- flush  in  1  insert a bubble (branch taken / squash)
- cnt_clr  in  1  synchronous clear of both counters
- out_valid  out  1  stage holds a real instruction
- out_ctrl  out  CTRL_W  registered control bundle, forced to 0 when out_valid=0
- out_data  out  DATA_W  registered data bundle
- stall_cnt  out  CNT_W  number of cycles this stage was held with a valid instruction
- bubble_cnt  out  CNT_W  number of bubbles created by flush

Behaviour:
- Latency: 1 cycle from in_* to out_* when neither stall nor flush is asserted.
- Reset values: out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, bubble_cnt=0.
- Per-edge update priority, highest first: Reset > flush > stall > load.
  - Reset: all registers take their reset values. Reset asserted mid-operation discards the current contents on that same edge.
  - flush=1: out_valid<=0 and out_ctrl<=0. out_data<=0 if CLEAR_DATA_ON_FLUSH=1, otherwise out_data is held. flush overrides stall when both are asserted on the same edge.
  - stall=1, flush=0: out_valid, out_ctrl and out_data are held unchanged. in_* is ignored.
  - Otherwise (load): out_valid<=in_valid. out_ctrl<=in_valid ? in_ctrl : 0. out_data<=in_data.
- Control gating: out_ctrl is 0 in every cycle where out_valid=0, so a bubble can never assert an RF, HI/LO or memory enable downstream.
- bubble_cnt increments on a flush edge only if the stage held a valid instruction (out_valid=1 before the edge) or in_valid=1. A flush of an already-empty stage with in_valid=0 does not count.
- stall_cnt increments on each edge with stall=1, flush=0 and out_valid=1. Stalling an empty stage does not count.
- Counters saturate at 2^CNT_W-1 with no wrap.
- Counter priority: Reset > cnt_clr > increment. cnt_clr on an edge that would also increment sets the counter to 0. cnt_clr does not affect out_*.
- No combinational path from any input to any output. All outputs come straight from flops.
- Stall and flush are level signals sampled each edge. Holding stall for N edges holds the contents for N cycles, and the stage releases on the first edge where stall=0.

Test Plan:
1. Reset, then in_valid=1, in_ctrl=16'hA5A5, in_data=96'h1234 with stall=flush=0 → one edge later out_valid=1, out_ctrl=16'hA5A5, out_data=96'h1234. Counters stay 0.
2. Load 16'h00F1, then stall=1 for 3 edges while in_ctrl changes every cycle → outputs stay 16'h00F1 and stall_cnt=3. On release, the next edge loads the current input.
3. Valid instruction held, then stall=1 and flush=1 on the same edge → out_valid=0, out_ctrl=0, bubble_cnt=1, stall_cnt unchanged. out_data is held with CLEAR_DATA_ON_FLUSH=0 and zero with CLEAR_DATA_ON_FLUSH=1.
4. in_valid=0 with in_ctrl=16'hFFFF → out_valid=0 and out_ctrl=0. A flush with the stage empty and in_valid=0 leaves bubble_cnt unchanged.
5. CNT_W=4, hold a valid instruction under stall for 20 edges → stall_cnt saturates at 15. Assert cnt_clr while stall is still 1 → stall_cnt=0 on that edge, then 1 on the following edge.
6. Valid instruction flowing with counters nonzero, Reset asserted for 1 cycle → all outputs and counters are 0 on that edge. The next valid input loads normally one edge after Reset deasserts.
